// File: rtl/wps_pkg.sv
// Shared types and sizes for the WPS line-read path.
package wps_pkg;

    localparam int unsigned FIFO_DEPTH = 512;
    localparam int unsigned DATA_W     = 24;
    localparam int unsigned WORD_CNT_W = 10;
    localparam int unsigned LINE_CNT_W = 16;
    localparam int unsigned GAP_CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_READ,
        ST_GAP,
        ST_DONE
    } wps_state_e;

endpackage

// File: rtl/wps_down_counter.sv
// Loadable down-counter that stops at zero and flags it.
module wps_down_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/wps_line_read_ctrl.sv
// Read-side sequencer for the tx-domain line FIFO: bursts whole lines,
// spaces them by a programmable gap and groups them into frames.
module wps_line_read_ctrl
    import wps_pkg::*;
#(
    parameter int unsigned LINE_WORDS      = 256,
    parameter int unsigned LINES_PER_FRAME = 1024,
    parameter int unsigned GAP_CYCLES      = 4,
    parameter int unsigned USEDW_W         = 9
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst_n,
    input  logic                  frame_start,
    input  logic                  wps_send_done_in,
    input  logic [USEDW_W-1:0]    fifo_rdusedw,
    input  logic                  fifo_empty,
    input  logic                  sink_ready,
    output logic                  fifo_rd_en,
    output logic                  line_active,
    output logic                  line_start,
    output logic [WORD_CNT_W-1:0] word_cnt,
    output logic [LINE_CNT_W-1:0] line_cnt,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  underrun_err
);

    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    if (LINE_WORDS < 1 || LINE_WORDS > FIFO_DEPTH || LINE_WORDS >= (32'd1 << USEDW_W))
    begin : g_bad_line_words
        $error("wps_line_read_ctrl: LINE_WORDS does not fit fifo_rdusedw");
    end

    wps_state_e            state_q, state_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic                  line_start_q, line_start_d;
    logic                  frame_done_q, frame_done_d;
    logic                  underrun_q, underrun_d;
    logic                  rd_en_c;
    logic                  last_word_c;
    logic                  gap_load_c;
    logic                  gap_dec_c;
    logic                  gap_zero_c;

    wps_down_counter #(
        .W (GAP_CNT_W)
    ) u_gap_cnt (
        .clk      (tx_clk),
        .rst_n    (tx_rst_n),
        .load     (gap_load_c),
        .load_val (GAP_CNT_W'(GAP_LOAD)),
        .dec      (gap_dec_c),
        .zero_c   (gap_zero_c)
    );

    // Abort masks the read strobe in the same cycle it is raised.
    assign rd_en_c     = (state_q == ST_READ) & ~fifo_empty & sink_ready & ~wps_send_done_in;
    assign last_word_c = rd_en_c & (word_cnt_q == WORD_CNT_W'(LINE_WORDS - 1));

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        line_cnt_d   = line_cnt_q;
        line_start_d = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = underrun_q;
        gap_load_c   = 1'b0;
        gap_dec_c    = 1'b0;

        if (wps_send_done_in) begin
            state_d    = ST_IDLE;
            word_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_d    = ST_WAIT_DATA;
                        line_cnt_d = '0;
                        underrun_d = 1'b0;
                    end
                end
                ST_WAIT_DATA: begin
                    if (32'(fifo_rdusedw) >= LINE_WORDS) begin
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    if (fifo_empty) begin
                        underrun_d = 1'b1;
                    end
                    if (rd_en_c) begin
                        word_cnt_d   = word_cnt_q + WORD_CNT_W'(1);
                        line_start_d = (word_cnt_q == '0);
                    end
                    if (last_word_c) begin
                        word_cnt_d = '0;
                        line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
                        if (line_cnt_q == LINE_CNT_W'(LINES_PER_FRAME - 1)) begin
                            state_d      = ST_DONE;
                            frame_done_d = 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            state_d = ST_WAIT_DATA;
                        end else begin
                            state_d    = ST_GAP;
                            gap_load_c = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_zero_c) begin
                        state_d = ST_WAIT_DATA;
                    end else begin
                        gap_dec_c = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            line_cnt_q   <= '0;
            line_start_q <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            line_cnt_q   <= line_cnt_d;
            line_start_q <= line_start_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign fifo_rd_en   = rd_en_c;
    assign line_active  = (state_q == ST_READ);
    assign busy         = (state_q != ST_IDLE);
    assign line_start   = line_start_q;
    assign word_cnt     = word_cnt_q;
    assign line_cnt     = line_cnt_q;
    assign frame_done   = frame_done_q;
    assign underrun_err = underrun_q;

endmodule

// File: tb/tb_wps_line_read_ctrl.sv
// Bench for wps_line_read_ctrl: directed scenarios plus random traffic,
// checked cycle by cycle against a line/frame bookkeeping model.
module tb_wps_line_read_ctrl;

    localparam int unsigned LW  = 8;
    localparam int unsigned LPF = 4;
    localparam int unsigned GAP = 2;
    localparam int unsigned UW  = 9;

    logic          tx_clk = 1'b0;
    logic          tx_rst_n;
    logic          frame_start;
    logic          wps_send_done_in;
    logic [UW-1:0] fifo_rdusedw;
    logic          fifo_empty;
    logic          sink_ready;
    logic          fifo_rd_en;
    logic          line_active;
    logic          line_start;
    logic [9:0]    word_cnt;
    logic [15:0]   line_cnt;
    logic          frame_done;
    logic          busy;
    logic          underrun_err;

    wps_line_read_ctrl #(
        .LINE_WORDS      (LW),
        .LINES_PER_FRAME (LPF),
        .GAP_CYCLES      (GAP),
        .USEDW_W         (UW)
    ) dut (
        .tx_clk           (tx_clk),
        .tx_rst_n         (tx_rst_n),
        .frame_start      (frame_start),
        .wps_send_done_in (wps_send_done_in),
        .fifo_rdusedw     (fifo_rdusedw),
        .fifo_empty       (fifo_empty),
        .sink_ready       (sink_ready),
        .fifo_rd_en       (fifo_rd_en),
        .line_active      (line_active),
        .line_start       (line_start),
        .word_cnt         (word_cnt),
        .line_cnt         (line_cnt),
        .frame_done       (frame_done),
        .busy             (busy),
        .underrun_err     (underrun_err)
    );

    always #5 tx_clk = ~tx_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int lvl     = 0;
    int cyc     = 0;

    // Model: a frame is "armed" from frame_start until the cycle after its
    // last word; between lines it sits out GAP idle cycles then one data check.
    bit m_armed, m_reading, m_finishing, m_err, m_ls;
    int m_holdoff, m_words, m_lines;

    int rd_total, fd_total, first_rd, last_rd, eighth_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_reading = 0; m_finishing = 0; m_err = 0; m_ls = 0;
        m_holdoff = 0; m_words = 0; m_lines = 0;
    endtask

    task automatic clear_stats();
        rd_total = 0; fd_total = 0; first_rd = -1; last_rd = -1; eighth_rd = -1;
    endtask

    // One clock: drive at negedge, check strobe, clock, check registered outputs.
    task automatic step(input bit fs, input bit ab, input bit rdy, input bit fe, input bit add);
        bit exp_rd;
        int uw;
        uw               = (lvl > 511) ? 511 : lvl;
        frame_start      = fs;
        wps_send_done_in = ab;
        sink_ready       = rdy;
        fifo_rdusedw     = UW'(uw);
        fifo_empty       = fe || (lvl == 0);
        #1;
        exp_rd = m_reading && !fifo_empty && rdy && !ab;
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        @(posedge tx_clk);
        m_ls = 0;
        if (ab) begin
            m_armed = 0; m_reading = 0; m_finishing = 0; m_holdoff = 0; m_words = 0;
        end else if (!m_armed) begin
            if (fs) begin
                m_armed = 1; m_lines = 0; m_err = 0;
            end
        end else if (m_finishing) begin
            m_armed = 0; m_finishing = 0;
        end else if (m_reading) begin
            if (fifo_empty) m_err = 1;
            if (exp_rd) begin
                if (m_words == 0) m_ls = 1;
                m_words++;
                if (m_words == int'(LW)) begin
                    m_words = 0;
                    m_lines++;
                    m_reading = 0;
                    if (m_lines == int'(LPF)) m_finishing = 1;
                    else m_holdoff = GAP;
                end
            end
        end else if (m_holdoff > 0) begin
            m_holdoff--;
        end else if (uw >= int'(LW)) begin
            m_reading = 1;
        end
        if (exp_rd) begin
            lvl--;
            rd_total++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (rd_total == 8) eighth_rd = cyc;
        end
        if (add) lvl++;
        cyc++;
        #1;
        check("word_cnt", 32'(word_cnt), 32'(m_words));
        check("line_cnt", 32'(line_cnt), 32'(m_lines));
        check("line_start", 32'(line_start), 32'(m_ls));
        check("frame_done", 32'(frame_done), 32'(m_finishing));
        check("busy", 32'(busy), 32'(m_armed));
        check("line_active", 32'(line_active), 32'(m_reading));
        check("underrun_err", 32'(underrun_err), 32'(m_err));
        if (frame_done) fd_total++;
        @(negedge tx_clk);
    endtask

    initial begin
        bit reached;
        int forced;
        tx_rst_n = 1'b0; frame_start = 0; wps_send_done_in = 0;
        fifo_rdusedw = '0; fifo_empty = 1; sink_ready = 0;
        model_reset();
        #3;
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        check("rst_line_cnt", 32'(line_cnt), 32'd0);
        check("rst_underrun", 32'(underrun_err), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge tx_clk);
        tx_rst_n = 1'b1;

        // Full frame from a pre-filled FIFO.
        lvl = 32; clear_stats();
        step(1, 0, 1, 0, 0);
        repeat (60) step(0, 0, 1, 0, 0);
        check("s1_reads", 32'(rd_total), 32'd32);
        check("s1_span", 32'(last_rd - first_rd + 1), 32'(LPF * LW + (LPF - 1) * (GAP + 1)));
        check("s1_frame_done_cnt", 32'(fd_total), 32'd1);
        check("s1_line_cnt", 32'(line_cnt), 32'(LPF));
        check("s1_underrun", 32'(underrun_err), 32'd0);

        // Not enough data buffered: wait, then read the cycle after 8 appear.
        begin
            int c8;
            lvl = 5; clear_stats();
            step(1, 0, 1, 0, 0);
            repeat (20) step(0, 0, 1, 0, 0);
            check("s2_no_read", 32'(rd_total), 32'd0);
            lvl = 8; c8 = cyc;
            repeat (80) step(0, 0, 1, 0, 1);
            check("s2_first_read", 32'(first_rd), 32'(c8 + 1));
            check("s2_frame_done_cnt", 32'(fd_total), 32'd1);
        end

        // Alternating sink_ready: 8 reads spread over 15 cycles.
        lvl = 32; clear_stats();
        step(1, 0, 1, 0, 0);
        for (int k = 0; k < 40; k++) step(0, 0, (k % 2) == 0, 0, 0);
        check("s3_line_span", 32'(eighth_rd - first_rd + 1), 32'd15);
        repeat (60) step(0, 0, 1, 0, 0);
        check("s3_frame_done_cnt", 32'(fd_total), 32'd1);

        // Three empty cycles at word 4: underrun latches, line still completes.
        lvl = 32; clear_stats(); forced = 0;
        step(1, 0, 1, 0, 0);
        for (int k = 0; k < 30; k++) begin
            if (m_reading && m_words == 4 && forced < 3) begin
                step(0, 0, 1, 1, 0);
                forced++;
            end else begin
                step(0, 0, 1, 0, 0);
            end
        end
        check("s4_line_span", 32'(eighth_rd - first_rd + 1), 32'd11);
        check("s4_underrun", 32'(underrun_err), 32'd1);
        repeat (50) step(0, 0, 1, 0, 0);
        check("s4_underrun_sticky", 32'(underrun_err), 32'd1);
        step(1, 0, 0, 0, 0);
        check("s4_underrun_clr", 32'(underrun_err), 32'd0);
        step(0, 1, 0, 0, 0);

        // Abort at word 5 of the second line.
        lvl = 40; clear_stats(); reached = 0;
        step(1, 0, 1, 0, 0);
        for (int k = 0; k < 200; k++) begin
            if (m_reading && m_lines == 1 && m_words == 5) begin
                reached = 1;
                break;
            end
            step(0, 0, 1, 0, 0);
        end
        check("s5_reach_abort_point", 32'(reached), 32'd1);
        step(0, 1, 1, 0, 0);
        check("s5_busy_after_abort", 32'(busy), 32'd0);
        check("s5_line_cnt_hold", 32'(line_cnt), 32'd1);
        step(1, 1, 1, 0, 0);
        check("s5_start_with_abort", 32'(busy), 32'd0);
        repeat (8) step(0, 0, 1, 0, 0);
        check("s5_no_frame_done", 32'(fd_total), 32'd0);
        step(1, 0, 1, 0, 0);
        check("s5_restart_line_cnt", 32'(line_cnt), 32'd0);
        repeat (80) step(0, 0, 1, 0, 1);

        // Asynchronous reset mid-line.
        lvl = 32; clear_stats(); reached = 0;
        step(1, 0, 1, 0, 0);
        for (int k = 0; k < 50; k++) begin
            if (m_reading && m_words >= 3) begin
                reached = 1;
                break;
            end
            step(0, 0, 1, 0, 0);
        end
        check("s6_reach_read", 32'(reached), 32'd1);
        #2 tx_rst_n = 1'b0;
        #1;
        check("s6_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("s6_rst_active", 32'(line_active), 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_word_cnt", 32'(word_cnt), 32'd0);
        check("s6_rst_line_start", 32'(line_start), 32'd0);
        model_reset();
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
        repeat (5) step(0, 0, 1, 0, 0);
        check("s6_idle_after_rst", 32'(busy), 32'd0);
        step(1, 0, 1, 0, 0);
        repeat (80) step(0, 0, 1, 0, 1);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 10) == 0, ($urandom % 60) == 0, ($urandom % 10) < 7,
                 ($urandom % 25) == 0, (lvl < 500) && (($urandom % 10) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wps_line_read_ctrl.md
Name: wps_line_read_ctrl

Overview:
- Read-side sequencer for the dual-clock 24-bit x 512 line FIFO in the tx clock domain.
- Drives the FIFO read enable in fixed-length line bursts, LINE_WORDS words per line, and frames the bursts into LINES_PER_FRAME lines.
- Starts a burst only when a full line is buffered, inserts a programmable inter-line gap, and honours downstream back-pressure.
- Replaces free-running external read strobes. Provides line/word counters and a sticky underrun flag for debug probes.

Parameters:
- LINE_WORDS, 256, words per line burst (1..512).
- LINES_PER_FRAME, 1024, lines per frame (1..65535).
- GAP_CYCLES, 4, idle cycles between line bursts (0..255; 0 = back-to-back).
- USEDW_W, 9, width of FIFO read-used-words input.

Ports:
- tx_clk, input, 1, read-domain clock.
- tx_rst_n, input, 1, asynchronous active-low reset.
- frame_start, input, 1, single-cycle pulse that arms a new frame.
- wps_send_done_in, input, 1, abort/flush: return to IDLE.
- fifo_rdusedw, input, USEDW_W, FIFO words available (read side).
- fifo_empty, input, 1, FIFO rdempty.
- sink_ready, input, 1, downstream can accept a word this cycle.
- fifo_rd_en, output, 1, FIFO rdreq (combinational).
- line_active, output, 1, high while in READ.
- line_start, output, 1, one-cycle pulse on the first read of each line.
- word_cnt, output, 10, words read in current line.
- line_cnt, output, 16, completed lines in current frame.
- frame_done, output, 1, one-cycle pulse after the last word of the last line.
- busy, output, 1, state != IDLE.
- underrun_err, output, 1, sticky: the FIFO went empty mid-line.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - word_cnt, line_cnt, frame_done, line_start and underrun_err = 0.
  - fifo_rd_en = 0.
- State IDLE:
  - frame_start moves to WAIT_DATA.
  - line_cnt and underrun_err clear on that transition.
- State WAIT_DATA:
  - Moves to READ when fifo_rdusedw >= LINE_WORDS.
  - Compare is unsigned, zero-extended.
  - LINE_WORDS = 512 is valid only with USEDW_W >= 10; the value is checked by elaboration assert.
- State READ:
  - fifo_rd_en = ~fifo_empty & sink_ready, combinational and same-cycle.
  - Each cycle with fifo_rd_en = 1 increments word_cnt.
  - line_start pulses, registered, the cycle after the first read of the line.
  - When a read occurs with word_cnt == LINE_WORDS-1:
    - word_cnt goes to 0 and line_cnt increments.
    - If line_cnt was LINES_PER_FRAME-1, go to DONE.
    - Otherwise go to GAP, or to WAIT_DATA if GAP_CYCLES = 0.
- Stalls in READ:
  - sink_ready = 0 simply stalls; no error.
  - fifo_empty = 1 while in READ stalls and sets underrun_err (sticky until next frame_start or reset).
- State GAP: gap counter counts GAP_CYCLES cycles, then moves to WAIT_DATA.
- State DONE:
  - frame_done = 1 for exactly one cycle, then IDLE.
  - line_cnt holds the final value until the next frame_start.
- Abort: wps_send_done_in = 1 in any state gives the next state IDLE, word_cnt = 0 and fifo_rd_en = 0 in the same cycle. It has priority over all other transitions; line_cnt holds.
- frame_start outside IDLE is ignored.
- frame_start coincident with wps_send_done_in: abort wins and the frame is not armed.
- Throughput: with sink_ready and data present, one word per cycle.
  - Line period = LINE_WORDS + GAP_CYCLES + 1 cycles (one cycle in WAIT_DATA).
  - That WAIT_DATA cycle is present even when data is already buffered.
- Counters never wrap within a frame. line_cnt saturation is not needed because DONE terminates the frame.

Decomposition:
- Shared package wps_pkg:
  - state enum (IDLE, WAIT_DATA, READ, GAP, DONE).
  - FIFO_DEPTH = 512.
  - DATA_W = 24.
- One natural sub-module: wps_down_counter, a loadable down-counter with a zero flag. It is used for the gap timer and can be reused for line counting.

Test Plan:
- LINE_WORDS=8, LINES_PER_FRAME=4, GAP_CYCLES=2, FIFO pre-filled with 32 words, sink_ready=1, pulse frame_start:
  - 4 bursts of 8 consecutive fifo_rd_en cycles, each burst separated by 3 non-read cycles.
  - line_cnt reaches 4 and frame_done pulses once.
  - underrun_err=0.
- Same setup, but fifo_rdusedw=5 for 20 cycles then 8: fifo_rd_en stays 0 throughout the wait; the first read occurs the cycle after rdusedw becomes 8.
- sink_ready toggled 1,0,1,0 during a line: reads occur only on sink_ready=1 cycles; the line completes after 8 reads in 15 cycles.
- Force fifo_empty=1 for 3 cycles mid-line (word_cnt=4): no reads during those cycles, underrun_err=1 sticky, and the line still completes with 8 reads total.
- Assert wps_send_done_in at word_cnt=5 of line 2:
  - fifo_rd_en=0 that cycle, state IDLE, busy=0 next cycle.
  - No frame_done.
  - A new frame_start restarts with line_cnt=0.
- tx_rst_n pulsed low asynchronously mid-READ: all outputs go to 0 immediately; after release, state is IDLE and frame_start is required to resume.
